// File: rtl/load_store_unit_if.sv
// Request/response handshake plus memory pins shared by the load/store unit
// and its environment (pipeline on the request side, word array on the memory side).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic        mem_enable;
    logic [31:0] mem_data_out;

    // View taken by the load/store unit itself.
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_data_in, mem_read_write, mem_enable
    );

    // View taken by the pipeline and memory that surround the unit.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_data_in, mem_read_write, mem_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, alignment and range checks,
// big-endian lane selection, and read-modify-write for byte/halfword stores.
module load_store_unit #(
    parameter logic [31:0] MEM_START = 32'h8002_0000,
    parameter int unsigned MEM_WORDS = 262144
) (
    input  logic              clock,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    // Range bounds in 33 bits so the upper limit cannot wrap past 2^32.
    localparam logic [32:0] RANGE_LO = {1'b0, MEM_START};
    localparam logic [32:0] RANGE_HI = RANGE_LO + (33'(MEM_WORDS) << 2);

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        req_fault;
    logic [32:0] addr_ext;

    // Request fields captured at the accept edge.
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] write_word;

    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_value;
    logic [31:0] load_ext;
    logic [31:0] merged_word;

    logic        mem_enable_raw;
    logic        mem_read_write_int;
    logic [31:0] mem_address_int;
    logic [31:0] mem_data_in_int;

    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;

    assign accept = bus.req_valid && bus.req_ready;

    // Fault classification of the incoming request, evaluated for the accept edge.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        req_fault = 1'b0;
        addr_ext  = {1'b0, bus.req_addr};
        case (bus.req_size)
            SIZE_HALF: req_fault = bus.req_addr[0];
            SIZE_WORD: req_fault = |bus.req_addr[1:0];
            SIZE_BAD:  req_fault = 1'b1;
            default:   req_fault = 1'b0;
        endcase
        if (addr_ext < RANGE_LO || addr_ext >= RANGE_HI) begin
            req_fault = 1'b1;
        end
    end

    // Big-endian lane select: offset 0 is the most significant byte.
    always_comb begin
        lane_shift  = 5'd0;
        lane_mask   = 32'hFFFF_FFFF;
        load_ext    = 32'h0;
        case (lat_size)
            SIZE_BYTE: begin
                lane_shift = {~lat_addr[1:0], 3'b000};
                lane_mask  = 32'h0000_00FF << lane_shift;
            end
            SIZE_HALF: begin
                lane_shift = {~lat_addr[1], 4'b0000};
                lane_mask  = 32'h0000_FFFF << lane_shift;
            end
            default: begin
                lane_shift = 5'd0;
                lane_mask  = 32'hFFFF_FFFF;
            end
        endcase

        lane_value = (bus.mem_data_out & lane_mask) >> lane_shift;

        case (lat_size)
            SIZE_BYTE: load_ext = lat_unsigned ? {24'h0, lane_value[7:0]}
                                               : {{24{lane_value[7]}}, lane_value[7:0]};
            SIZE_HALF: load_ext = lat_unsigned ? {16'h0, lane_value[15:0]}
                                               : {{16{lane_value[15]}}, lane_value[15:0]};
            default:   load_ext = lane_value;
        endcase

        merged_word = (bus.mem_data_out & ~lane_mask) | ((lat_wdata << lane_shift) & lane_mask);
    end

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and memory pin drive.
    always_comb begin
        state_next         = state;
        mem_enable_raw     = 1'b0;
        mem_read_write_int = 1'b1;
        mem_address_int    = 32'h0;
        mem_data_in_int    = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_next = RESP;
                    end else if (bus.req_write && bus.req_size == SIZE_WORD) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                mem_enable_raw  = 1'b1;
                mem_address_int = {lat_addr[31:2], 2'b00};
                state_next      = lat_write ? WRITE : RESP;
            end
            WRITE: begin
                mem_enable_raw     = 1'b1;
                mem_read_write_int = 1'b0;
                mem_address_int    = {lat_addr[31:2], 2'b00};
                mem_data_in_int    = write_word;
                state_next         = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture and store-data assembly; pure datapath, qualified by the FSM.
    always_ff @(posedge clock) begin
        // NOTE: these registers are never read before being loaded, so they carry no reset.
        if (accept) begin
            lat_write    <= bus.req_write;
            lat_size     <= bus.req_size;
            lat_unsigned <= bus.req_unsigned;
            lat_addr     <= bus.req_addr;
            lat_wdata    <= bus.req_wdata;
            write_word   <= bus.req_wdata;
        end else if (state == READ && lat_write) begin
            write_word <= merged_word;
        end
    end

    // Response registers, updated only on the transition into RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            if (accept && req_fault) begin
                resp_rdata_q <= 32'h0;
                resp_fault_q <= 1'b1;
            end else if (state == READ && !lat_write) begin
                resp_rdata_q <= load_ext;
                resp_fault_q <= 1'b0;
            end else if (state == WRITE) begin
                resp_rdata_q <= 32'h0;
                resp_fault_q <= 1'b0;
            end
        end
    end

    // Reset gates the enable directly so a write in flight never reaches the array.
    assign bus.mem_enable     = mem_enable_raw && !reset;
    assign bus.mem_read_write = mem_read_write_int;
    assign bus.mem_address    = mem_address_int;
    assign bus.mem_data_in    = mem_data_in_int;

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-array memory model.
module tb_load_store_unit;

    localparam logic [31:0] MEM_START = 32'h8002_0000;
    localparam int unsigned MEM_WORDS = 262144;

    logic clock;
    logic reset;
    logic mem_clear;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_model [0:63];

    load_store_unit_if bus ();

    load_store_unit #(
        .MEM_START (MEM_START),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: combinational read, write commits at the rising edge.
    assign bus.mem_data_out = (bus.mem_enable && bus.mem_read_write)
                              ? mem_model[bus.mem_address[7:2]] : 32'h0;

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem_model[i] <= 32'h0;
        end else if (bus.mem_enable && !bus.mem_read_write) begin
            mem_model[bus.mem_address[7:2]] <= bus.mem_data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
    endtask

    // Issue one request; called #1 after an edge. lat is the cycle (after accept)
    // in which resp_valid was seen, or -1 on timeout.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rdata,
                           output logic fault, output int en_cnt);
        int waited;
        waited = 0;
        lat    = -1;
        rdata  = 32'hxxxx_xxxx;
        fault  = 1'bx;
        en_cnt = 0;
        set_req(wr, sz, uns, addr, wd);
        bus.req_valid = 1'b1;
        while (!bus.req_ready && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.mem_enable) en_cnt++;
            if (bus.resp_valid) begin
                lat   = k;
                rdata = bus.resp_rdata;
                fault = bus.resp_fault;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic do_check(input string tag, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input int exp_lat, input logic [31:0] exp_rdata,
                            input logic exp_fault, input int exp_en);
        int          lat;
        logic [31:0] rdata;
        logic        fault;
        int          en_cnt;
        run_req(wr, sz, uns, addr, wd, lat, rdata, fault, en_cnt);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " fault"}, {31'h0, fault}, {31'h0, exp_fault});
        check({tag, " mem_enable cycles"}, 32'(en_cnt), 32'(exp_en));
    endtask

    logic [1:0]  q_size  [3];
    logic        q_uns   [3];
    logic [31:0] q_addr  [3];
    logic [31:0] q_exp   [3];

    initial begin
        int          idx;
        int          accepts;
        int          resps;
        int          late_resp;
        logic        acc;

        bus.req_valid = 1'b0;
        set_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        reset     = 1'b1;
        mem_clear = 1'b1;

        // Reset values.
        @(posedge clock); #1;
        check("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("reset resp_rdata", bus.resp_rdata, 32'h0);
        check("reset resp_fault", {31'h0, bus.resp_fault}, 32'h0);
        check("reset mem_enable", {31'h0, bus.mem_enable}, 32'h0);
        check("reset mem_address", bus.mem_address, 32'h0);
        check("reset mem_data_in", bus.mem_data_in, 32'h0);
        check("reset mem_read_write", {31'h0, bus.mem_read_write}, 32'h1);
        check("reset req_ready", {31'h0, bus.req_ready}, 32'h0);
        @(posedge clock); #1;
        reset     = 1'b0;
        mem_clear = 1'b0;
        #1;
        check("idle req_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clock); #1;

        // Word store then load.
        do_check("SW 0010", 1'b1, 2'b10, 1'b0, 32'h8002_0010, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1);
        check("SW 0010 memory", mem_model[4], 32'hDEAD_BEEF);
        do_check("LW 0010", 1'b0, 2'b10, 1'b0, 32'h8002_0010, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1);

        // Byte read-modify-write and byte loads.
        do_check("SW 0020", 1'b1, 2'b10, 1'b0, 32'h8002_0020, 32'h1122_3344, 2, 32'h0, 1'b0, 1);
        do_check("SB 0021", 1'b1, 2'b00, 1'b0, 32'h8002_0021, 32'h0000_00AA, 3, 32'h0, 1'b0, 2);
        check("SB 0021 memory", mem_model[8], 32'h11AA_3344);
        do_check("LB 0021", 1'b0, 2'b00, 1'b0, 32'h8002_0021, 32'h0, 2, 32'hFFFF_FFAA, 1'b0, 1);
        do_check("LBU 0021", 1'b0, 2'b00, 1'b1, 32'h8002_0021, 32'h0, 2, 32'h0000_00AA, 1'b0, 1);

        // Halfword read-modify-write and halfword loads.
        do_check("SH 0022", 1'b1, 2'b01, 1'b0, 32'h8002_0022, 32'h0000_8001, 3, 32'h0, 1'b0, 2);
        check("SH 0022 memory", mem_model[8], 32'h11AA_8001);
        do_check("LH 0022", 1'b0, 2'b01, 1'b0, 32'h8002_0022, 32'h0, 2, 32'hFFFF_8001, 1'b0, 1);
        do_check("LHU 0020", 1'b0, 2'b01, 1'b1, 32'h8002_0020, 32'h0, 2, 32'h0000_11AA, 1'b0, 1);
        do_check("LB 0020", 1'b0, 2'b00, 1'b0, 32'h8002_0020, 32'h0, 2, 32'h0000_0011, 1'b0, 1);

        // Faults: response in cycle 1, no memory access.
        do_check("fault LW 0002", 1'b0, 2'b10, 1'b0, 32'h8002_0002, 32'h0, 1, 32'h0, 1'b1, 0);
        do_check("fault SH 0001", 1'b1, 2'b01, 1'b0, 32'h8002_0001, 32'h5555, 1, 32'h0, 1'b1, 0);
        do_check("fault LW low", 1'b0, 2'b10, 1'b0, 32'h8001_FFFC, 32'h0, 1, 32'h0, 1'b1, 0);
        do_check("fault LW high", 1'b0, 2'b10, 1'b0, 32'h8012_0000, 32'h0, 1, 32'h0, 1'b1, 0);
        do_check("fault size 11", 1'b0, 2'b11, 1'b0, 32'h8002_0010, 32'h0, 1, 32'h0, 1'b1, 0);
        do_check("fault LB top wrap", 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 1, 32'h0, 1'b1, 0);
        // Last valid word is in range; after a fault, rdata returns to load data.
        do_check("LW last word", 1'b0, 2'b10, 1'b0, 32'h8011_FFFC, 32'h0, 2, mem_model[63], 1'b0, 1);

        // Reset asserted during the WRITE cycle of a word store.
        set_req(1'b1, 2'b10, 1'b0, 32'h8002_0030, 32'h1234_5678);
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst-write mem_enable", {31'h0, bus.mem_enable}, 32'h0);
        check("rst-write req_ready", {31'h0, bus.req_ready}, 32'h0);
        @(posedge clock); #1;
        check("rst-write resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst-write memory", mem_model[12], 32'h0);
        reset = 1'b0;
        #1;
        check("rst-write ready after", {31'h0, bus.req_ready}, 32'h1);
        late_resp = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            if (bus.resp_valid) late_resp++;
        end
        check("rst-write dropped resp", 32'(late_resp), 32'h0);
        do_check("LW 0030 after rst", 1'b0, 2'b10, 1'b0, 32'h8002_0030, 32'h0, 2, 32'h0, 1'b0, 1);

        // Back-to-back: req_valid stays high across three queued loads.
        q_size[0] = 2'b10; q_uns[0] = 1'b0; q_addr[0] = 32'h8002_0010; q_exp[0] = 32'hDEAD_BEEF;
        q_size[1] = 2'b00; q_uns[1] = 1'b1; q_addr[1] = 32'h8002_0023; q_exp[1] = 32'h0000_0001;
        q_size[2] = 2'b01; q_uns[2] = 1'b0; q_addr[2] = 32'h8002_0020; q_exp[2] = 32'h0000_11AA;
        idx     = 0;
        accepts = 0;
        resps   = 0;
        set_req(1'b0, q_size[0], q_uns[0], q_addr[0], 32'h0);
        bus.req_valid = 1'b1;
        for (int c = 0; c < 40 && resps < 3; c++) begin
            acc = bus.req_valid && bus.req_ready;
            @(posedge clock); #1;
            if (acc) begin
                accepts++;
                idx++;
                if (idx < 3) set_req(1'b0, q_size[idx], q_uns[idx], q_addr[idx], 32'h0);
                else bus.req_valid = 1'b0;
            end
            if (bus.resp_valid) begin
                if (resps < 3) begin
                    check($sformatf("b2b rdata %0d", resps), bus.resp_rdata, q_exp[resps]);
                    check($sformatf("b2b fault %0d", resps), {31'h0, bus.resp_fault}, 32'h0);
                end
                resps++;
            end
        end
        check("b2b accepts", 32'(accepts), 32'd3);
        check("b2b responses", 32'(resps), 32'd3);
        @(posedge clock); #1;
        check("b2b no extra resp", {31'h0, bus.resp_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
